// File: rtl/alu_issue_ctrl_pkg.sv
// alu_pkg: shared ALU op encodings, ARM condition codes and NZVC flag layout.
// Used by alu_issue_ctrl, its condition checker and the branch unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PLUS      = 4'd0,
    OP_CPLUS     = 4'd1,
    OP_MINUS     = 4'd2,
    OP_REVMINUS  = 4'd3,
    OP_CMINUS    = 4'd4,
    OP_REVCMINUS = 4'd5,
    OP_MULT      = 4'd6,
    OP_AND       = 4'd7,
    OP_XOR       = 4'd8,
    OP_OR        = 4'd9,
    OP_NOT       = 4'd10,
    OP_CLEAR     = 4'd11,
    OP_RRX       = 4'd12,
    OP_MOVE      = 4'd13
  } alu_op_e;

  typedef enum logic [3:0] {
    C_EQ = 4'd0,  C_NE = 4'd1,  C_CS = 4'd2,  C_CC = 4'd3,
    C_MI = 4'd4,  C_PL = 4'd5,  C_VS = 4'd6,  C_VC = 4'd7,
    C_HI = 4'd8,  C_LS = 4'd9,  C_GE = 4'd10, C_LT = 4'd11,
    C_GT = 4'd12, C_LE = 4'd13, C_AL = 4'd14, C_NV = 4'd15
  } cond_e;

  typedef logic [3:0] nzvc_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // Encodings 14 and 15 have no ALU operation behind them.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op >= 4'd14);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request/response bus between issue logic and alu_issue_ctrl.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the payload must be stable while valid is high and ready is low,
// and the sender may not withdraw valid before the transfer.
//  master: issuer side (drives req_*, rsp_ready)
//  slave : alu_issue_ctrl side (drives req_ready, rsp_*)
interface alu_issue_ctrl_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [3:0]       req_cond;
  logic             req_setf;
  logic [WIDTH-1:0] req_src1;
  logic [WIDTH-1:0] req_src2;
  logic             req_shc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_exec;
  logic             rsp_illegal;

  modport master (
    output req_valid, req_op, req_cond, req_setf, req_src1, req_src2, req_shc, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_exec, rsp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_cond, req_setf, req_src1, req_src2, req_shc, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_exec, rsp_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl_cond_check.sv
// cond_check: combinational ARM condition evaluation against NZVC flags.
//  cond : condition code
//  nzvc : flags to test
//  pass : 1 when the condition holds
module cond_check
  import alu_pkg::*;
(
  input  cond_e cond,
  input  nzvc_t nzvc,
  output logic  pass
);
  logic n, z, v, c;

  assign n = nzvc[FLAG_N];
  assign z = nzvc[FLAG_Z];
  assign v = nzvc[FLAG_V];
  assign c = nzvc[FLAG_C];

  always_comb begin
    pass = 1'b0;
    case (cond)
      C_EQ: pass = z;
      C_NE: pass = !z;
      C_CS: pass = c;
      C_CC: pass = !c;
      C_MI: pass = n;
      C_PL: pass = !n;
      C_VS: pass = v;
      C_VC: pass = !v;
      C_HI: pass = c && !z;
      C_LS: pass = !c || z;
      C_GE: pass = (n == v);
      C_LT: pass = (n != v);
      C_GT: pass = !z && (n == v);
      C_LE: pass = z || (n != v);
      C_AL: pass = 1'b1;
      C_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one ALU operation per request, owns the NZVC flags.
//  clk, reset          : clock, async active-high reset
//  bus (slave)         : request/response handshake bus
//  alu_src1/2, alu_ctrl: operands and op code to the combinational ALU
//  alu_carr, alu_c     : current C flag and shifter carry to the ALU
//  alu_nzvc, alu_result: ALU outputs, sampled only at capture
//  flags               : architectural NZVC
//  flags_load/flags_in : external flag write
//  fsm_state           : current FSM state (IDLE=0 EXEC=1 MULW=2 DONE=3)
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  alu_issue_ctrl_if.slave   bus,
  output logic [WIDTH-1:0]  alu_src1,
  output logic [WIDTH-1:0]  alu_src2,
  output logic [3:0]        alu_ctrl,
  output logic              alu_carr,
  output logic              alu_c,
  input  logic [3:0]        alu_nzvc,
  input  logic [WIDTH-1:0]  alu_result,
  output logic [3:0]        flags,
  input  logic              flags_load,
  input  logic [3:0]        flags_in,
  output logic [1:0]        fsm_state
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MULW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam bit         MUL_ONE  = (MUL_CYCLES == 1);
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  logic [1:0]       state;
  logic [3:0]       op_q;
  logic             setf_q;
  logic [WIDTH-1:0] src1_q, src2_q;
  logic             shc_q;
  logic [3:0]       cnt;
  nzvc_t            flags_q;
  logic             cond_pass;
  logic             mult_wait;
  logic             capture;

  // Condition is judged on the flags as they stand at accept, so a
  // coincident flags_load only takes effect for later requests.
  cond_check u_cond (
    .cond (cond_e'(bus.req_cond)),
    .nzvc (flags_q),
    .pass (cond_pass)
  );

  assign mult_wait = (op_q == OP_MULT) && !MUL_ONE;
  // MULW counts down from MUL_CYCLES-1; capture on the cycle it shows 1,
  // giving MUL_CYCLES+1 cycles from accept to response.
  assign capture   = ((state == S_EXEC) && !mult_wait) ||
                     ((state == S_MULW) && (cnt == 4'd1));

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_DONE);
  assign alu_src1      = src1_q;
  assign alu_src2      = src2_q;
  assign alu_ctrl      = op_q;
  assign alu_carr      = flags_q[FLAG_C];
  assign alu_c         = shc_q;
  assign flags         = flags_q;
  assign fsm_state     = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      op_q            <= 4'(OP_MOVE);
      setf_q          <= 1'b0;
      src1_q          <= '0;
      src2_q          <= '0;
      shc_q           <= 1'b0;
      cnt             <= '0;
      bus.rsp_result  <= '0;
      bus.rsp_exec    <= 1'b0;
      bus.rsp_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q   <= bus.req_op;
            setf_q <= bus.req_setf;
            src1_q <= bus.req_src1;
            src2_q <= bus.req_src2;
            shc_q  <= bus.req_shc;
            if (op_illegal(bus.req_op)) begin
              bus.rsp_illegal <= 1'b1;
              bus.rsp_exec    <= 1'b0;
              bus.rsp_result  <= '0;
              state           <= S_DONE;
            end else if (!cond_pass) begin
              bus.rsp_exec   <= 1'b0;
              bus.rsp_result <= '0;
              state          <= S_DONE;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (mult_wait) begin
            cnt   <= MUL_LOAD;
            state <= S_MULW;
          end else begin
            bus.rsp_result <= alu_result;
            bus.rsp_exec   <= 1'b1;
            state          <= S_DONE;
          end
        end
        S_MULW: begin
          if (cnt == 4'd1) begin
            bus.rsp_result <= alu_result;
            bus.rsp_exec   <= 1'b1;
            state          <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_result  <= '0;
            bus.rsp_exec    <= 1'b0;
            bus.rsp_illegal <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A setf capture outranks an external load landing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else if (capture && setf_q) begin
      flags_q <= alu_nzvc;
    end else if (flags_load) begin
      flags_q <= flags_in;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int W = 46;  // {lat[7:0], result[31:0], exec, illegal, flags[3:0]}

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.WIDTH(32)) bus ();

  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_ctrl, alu_nzvc, flags, flags_in;
  logic        alu_carr, alu_c, flags_load;
  logic [1:0]  fsm_state;

  alu_issue_ctrl #(.WIDTH(32), .MUL_CYCLES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_ctrl   (alu_ctrl),
    .alu_carr   (alu_carr),
    .alu_c      (alu_c),
    .alu_nzvc   (alu_nzvc),
    .alu_result (alu_result),
    .flags      (flags),
    .flags_load (flags_load),
    .flags_in   (flags_in),
    .fsm_state  (fsm_state)
  );

  // combinational ALU stand-in
  function automatic logic [33:0] addv(input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    return {(a[31] == b[31]) && (s[31] != a[31]), s};
  endfunction

  logic [33:0] t;
  logic [63:0] prod;
  always_comb begin
    t    = {1'b0, alu_c, 32'd0};
    prod = '0;
    case (alu_ctrl)
      4'd0:  t = addv(alu_src1, alu_src2, 1'b0);
      4'd1:  t = addv(alu_src1, alu_src2, alu_carr);
      4'd2:  t = addv(alu_src1, ~alu_src2, 1'b1);
      4'd3:  t = addv(alu_src2, ~alu_src1, 1'b1);
      4'd4:  t = addv(alu_src1, ~alu_src2, alu_carr);
      4'd5:  t = addv(alu_src2, ~alu_src1, alu_carr);
      4'd6: begin
        prod = 64'(alu_src1) * 64'(alu_src2);
        t    = {1'b0, |prod[63:32], prod[31:0]};
      end
      4'd7:  t = {1'b0, alu_c, alu_src1 & alu_src2};
      4'd8:  t = {1'b0, alu_c, alu_src1 ^ alu_src2};
      4'd9:  t = {1'b0, alu_c, alu_src1 | alu_src2};
      4'd10: t = {1'b0, alu_c, ~alu_src2};
      4'd11: t = {1'b0, alu_c, 32'd0};
      4'd12: t = {1'b0, alu_src2[0], alu_carr, alu_src2[31:1]};
      4'd13: t = {1'b0, alu_c, alu_src2};
      default: t = {1'b0, alu_c, 32'd0};
    endcase
    alu_result = t[31:0];
    alu_nzvc   = {t[31], t[31:0] == 32'd0, t[33], t[32]};
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int unsigned  cyc = 0;
  int unsigned  acc_cyc = 0;
  bit           seen = 1'b0;
  logic [W-1:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int lat, input logic [31:0] res,
                                      input logic ex, input logic ill, input logic [3:0] fl);
    return {8'(lat), res, ex, ill, fl};
  endfunction

  // monitor: compare each response the first cycle it is presented
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else if (bus.rsp_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("latency", 64'(cyc - acc_cyc), 64'(mon_e[45:38]));
        chk("result",  64'(bus.rsp_result), 64'(mon_e[37:6]));
        chk("exec",    64'(bus.rsp_exec), 64'(mon_e[5]));
        chk("illegal", 64'(bus.rsp_illegal), 64'(mon_e[4]));
        chk("flags",   64'(flags), 64'(mon_e[3:0]));
      end
    end else if (!bus.rsp_valid) begin
      seen = 1'b0;
    end
  end

  // driver tasks
  task automatic send(input logic [3:0] op, input logic [3:0] cond, input logic setf,
                      input logic [31:0] s1, input logic [31:0] s2, input logic shc,
                      input bit push, input logic [W-1:0] e);
    @(negedge clk);
    bus.req_op    = op;
    bus.req_cond  = cond;
    bus.req_setf  = setf;
    bus.req_src1  = s1;
    bus.req_src2  = s2;
    bus.req_shc   = shc;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    if (!bus.req_ready) begin
      chk("accept_timeout", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.req_ready && !bus.rsp_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic load_flags(input logic [3:0] v);
    @(posedge clk);
    #1;
    flags_load = 1'b1;
    flags_in   = v;
    @(posedge clk);
    #1;
    flags_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_cond  = '0;
    bus.req_setf  = 1'b0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    bus.req_shc   = 1'b0;
    bus.rsp_ready = 1'b1;
    flags_load    = 1'b0;
    flags_in      = '0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready",   64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid",   64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_result",  64'(bus.rsp_result), 64'd0);
    chk("rst_rsp_exec",    64'(bus.rsp_exec), 64'd0);
    chk("rst_rsp_illegal", 64'(bus.rsp_illegal), 64'd0);
    chk("rst_flags",       64'(flags), 64'd0);
    chk("rst_alu_ctrl",    64'(alu_ctrl), 64'd13);
    chk("rst_alu_src1",    64'(alu_src1), 64'd0);
    chk("rst_alu_src2",    64'(alu_src2), 64'd0);
    chk("rst_state",       64'(fsm_state), 64'd0);
    reset = 1'b0;

    // ADD overflow into sign bit
    send(OP_PLUS, C_AL, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1,
         mk(2, 32'h8000_0000, 1'b1, 1'b0, 4'b1010));
    wait_idle();

    // condition fails on loaded Z
    load_flags(4'b0100);
    send(OP_MINUS, C_NE, 1'b1, 32'd5, 32'd3, 1'b0, 1'b1,
         mk(1, 32'd0, 1'b0, 1'b0, 4'b0100));
    wait_idle();

    // MULT: 0x10000 * 0x10000 wraps to zero with carry
    send(OP_MULT, C_AL, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1,
         mk(4, 32'd0, 1'b1, 1'b0, 4'b0101));
    wait_idle();

    // illegal op, response held under back-pressure
    bus.rsp_ready = 1'b0;
    send(4'd15, C_AL, 1'b1, 32'd1, 32'd2, 1'b0, 1'b1,
         mk(1, 32'd0, 1'b0, 1'b1, 4'b0101));
    repeat (5) begin
      @(negedge clk);
      chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("stall_illegal",   64'(bus.rsp_illegal), 64'd1);
      chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
      chk("stall_flags",     64'(flags), 64'b0101);
    end
    bus.rsp_ready = 1'b1;
    wait_idle();

    // assorted conditions and ops
    send(OP_AND, C_EQ, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_FF00, 1'b1, 1'b1,
         mk(2, 32'h00F0_F000, 1'b1, 1'b0, 4'b0101));
    wait_idle();
    send(OP_CPLUS, C_CS, 1'b1, 32'd1, 32'd2, 1'b0, 1'b1,
         mk(2, 32'd4, 1'b1, 1'b0, 4'b0000));
    wait_idle();
    send(OP_XOR, C_NV, 1'b1, 32'hFFFF, 32'h1, 1'b0, 1'b1,
         mk(1, 32'd0, 1'b0, 1'b0, 4'b0000));
    wait_idle();
    send(OP_MINUS, C_GT, 1'b1, 32'd3, 32'd5, 1'b0, 1'b1,
         mk(2, 32'hFFFF_FFFE, 1'b1, 1'b0, 4'b1000));
    wait_idle();
    send(OP_MOVE, C_LT, 1'b0, 32'd0, 32'h1234, 1'b0, 1'b1,
         mk(2, 32'h1234, 1'b1, 1'b0, 4'b1000));
    wait_idle();

    // reset while waiting on MULT
    send(OP_MULT, C_AL, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mulw_state", 64'(fsm_state), 64'd2);
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_flags",     64'(flags), 64'd0);
    chk("midrst_state",     64'(fsm_state), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send(OP_PLUS, C_AL, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1,
         mk(2, 32'd0, 1'b1, 1'b0, 4'b0101));
    wait_idle();

    // external load on the capture edge loses to the ALU flags
    send(OP_PLUS, C_AL, 1'b1, 32'd1, 32'd1, 1'b0, 1'b1,
         mk(2, 32'd2, 1'b1, 1'b0, 4'b0000));
    flags_load = 1'b1;
    flags_in   = 4'b1111;
    @(posedge clk);
    #1;
    flags_load = 1'b0;
    wait_idle();

    // load on the accept edge: condition uses the old flags
    @(posedge clk);
    #1;
    flags_load = 1'b1;
    flags_in   = 4'b0100;
    send(OP_MOVE, C_EQ, 1'b0, 32'd0, 32'h55, 1'b0, 1'b1,
         mk(1, 32'd0, 1'b0, 1'b0, 4'b0100));
    flags_load = 1'b0;
    wait_idle();
    send(OP_MOVE, C_EQ, 1'b0, 32'd0, 32'h55, 1'b1, 1'b1,
         mk(2, 32'h55, 1'b1, 1'b0, 4'b0100));
    wait_idle();

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
